// File: rtl/blackjack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blackjack_pkg
//  Purpose  : Shared constants, state encoding and helper functions for the
//             blackjack controller and its card source.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package blackjack_pkg;

   // Game constants
   localparam logic [5:0] BJ_TARGET = 6'd21;
   localparam logic [5:0] ACE_BONUS = 6'd10;
   localparam logic [3:0] FACE_CAP  = 4'd10;

   // Controller state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_DEAL1 = 2'd1;
   localparam state_t ST_HITS  = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Folds any raw 4-bit value into a legal card value 1..10.
   // Zero and everything above the face cap count as a face card.
   function automatic logic [3:0] cap_card(input logic [3:0] raw);
      cap_card = ((raw == 4'd0) || (raw > FACE_CAP)) ? FACE_CAP : raw;
   endfunction

   // Effective total: an ace counts 11 whenever that does not bust the hand.
   function automatic logic [5:0] eff_sum(input logic [5:0] hard, input logic ace);
      eff_sum = (ace && (hard <= 6'd11)) ? (hard + ACE_BONUS) : hard;
   endfunction

endpackage
`default_nettype wire

// File: rtl/card_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : card_lfsr
//  Purpose  : Free-running 4-bit LFSR (x^4+x^3+1) mapped to card values 1..10.
//  Ports    : clk  - clock
//             rst  - synchronous active-high reset, loads SEED
//             card - card value derived from the current LFSR state
//  Revision : 1.0 - initial release
// ============================================================================
module card_lfsr
   import blackjack_pkg::*;
#(
   parameter logic [3:0] SEED = 4'b0001
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] card
);

   logic [3:0] lfsr;

   // Shift left, feedback from the two top taps; the all-zero state is never
   // reached from a nonzero seed, so the period is 15.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      end
   end

   always_comb begin
      card = cap_card(lfsr);
   end

endmodule
`default_nettype wire

// File: rtl/blackjack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : blackjack_ctrl
//  Purpose  : Four-card blackjack hand controller. Accepts draw pulses in
//             order, accumulates the hand and reports win/lose.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             card_os[3:0]      - one-cycle draw pulses, bit0 = first card
//             ext_card_en       - use ext_card instead of the LFSR
//             ext_card[3:0]     - external card value (1..10, others -> 10)
//             win_pulse/lose_pulse - one-cycle result strobes
//             win/lose          - latched result levels
//             hand_sum[5:0]     - effective hand total
//             card_cnt[2:0]     - cards accepted (0..4)
//             last_card[3:0]    - most recently accepted card
//  Revision : 1.0 - initial release
// ============================================================================
module blackjack_ctrl
   import blackjack_pkg::*;
#(
   parameter logic [3:0] LFSR_SEED = 4'b0001
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] card_os,
   input  logic       ext_card_en,
   input  logic [3:0] ext_card,
   output logic       win_pulse,
   output logic       lose_pulse,
   output logic       win,
   output logic       lose,
   output logic [5:0] hand_sum,
   output logic [2:0] card_cnt,
   output logic [3:0] last_card
);

   state_t     state;
   logic [5:0] hard;
   logic       ace;

   logic [3:0] lfsr_card;
   logic [3:0] card;
   logic       accept;
   logic       fresh;
   logic [5:0] base_hard;
   logic       base_ace;
   logic [2:0] base_cnt;
   logic [5:0] new_hard;
   logic       new_ace;
   logic [2:0] new_cnt;
   logic [5:0] new_sum;
   logic       res_win;
   logic       res_lose;

   card_lfsr #(
      .SEED (LFSR_SEED)
   ) u_card_lfsr (
      .clk  (clk),
      .rst  (rst),
      .card (lfsr_card)
   );

   always_comb begin
      card = ext_card_en ? cap_card(ext_card) : lfsr_card;
   end

   // Only the bit the current state is waiting for can be accepted.
   always_comb begin
      accept = 1'b0;
      case (state)
         ST_IDLE  : accept = card_os[0];
         ST_DEAL1 : accept = card_os[1];
         ST_HITS  : accept = ((card_cnt == 3'd2) && card_os[2]) ||
                             ((card_cnt == 3'd3) && card_os[3]);
         ST_DONE  : accept = card_os[0];
         default  : accept = 1'b0;
      endcase
   end

   // A first card (from IDLE or DONE) starts from an empty hand.
   always_comb begin
      fresh     = (state == ST_IDLE) || (state == ST_DONE);
      base_hard = fresh ? 6'd0 : hard;
      base_ace  = fresh ? 1'b0 : ace;
      base_cnt  = fresh ? 3'd0 : card_cnt;
      new_hard  = base_hard + {2'b00, card};
      new_ace   = base_ace | (card == 4'd1);
      new_cnt   = base_cnt + 3'd1;
      new_sum   = eff_sum(new_hard, new_ace);
      res_win   = (new_cnt >= 3'd2) && (new_sum == BJ_TARGET);
      res_lose  = (new_cnt >= 3'd2) && !res_win &&
                  ((new_sum > BJ_TARGET) || (new_cnt == 3'd4));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         hard       <= 6'd0;
         ace        <= 1'b0;
         card_cnt   <= 3'd0;
         last_card  <= 4'd0;
         win        <= 1'b0;
         lose       <= 1'b0;
         win_pulse  <= 1'b0;
         lose_pulse <= 1'b0;
      end else begin
         win_pulse  <= 1'b0;
         lose_pulse <= 1'b0;
         if (accept) begin
            hard       <= new_hard;
            ace        <= new_ace;
            card_cnt   <= new_cnt;
            last_card  <= card;
            win_pulse  <= res_win;
            lose_pulse <= res_lose;
            // Levels are rewritten on every accepted card: cleared when a new
            // game begins, set when this card decides the hand.
            win        <= res_win;
            lose       <= res_lose;
            if (res_win || res_lose) begin
               state <= ST_DONE;
            end else if (fresh) begin
               state <= ST_DEAL1;
            end else begin
               state <= ST_HITS;
            end
         end
      end
   end

   always_comb begin
      hand_sum = eff_sum(hard, ace);
   end

endmodule
`default_nettype wire

// File: doc/blackjack_ctrl.md
BLACKJACK_CTRL -- requirements
Module: blackjack_ctrl

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 4'b0001, meaning LFSR reset value; must be nonzero.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have port card_os, input, 4, one-cycle draw pulses from the four switch drivers; bit0 is the first card and bit3 is the fourth.
REQ-005 SHALL have port ext_card_en, input, 1, which selects ext_card instead of the LFSR as the card source.
REQ-006 SHALL have port ext_card, input, 4, external card value; valid range is 1..10.
REQ-007 SHALL have port win_pulse, output, 1, one-cycle pulse when the game is won.
REQ-008 SHALL have port lose_pulse, output, 1, one-cycle pulse when the game is lost.
REQ-009 SHALL have ports win and lose, output, 1 each, latched result levels for the LEDs.
REQ-010 SHALL have port hand_sum, output, 6, effective hand total for the display.
REQ-011 SHALL have port card_cnt, output, 3, number of cards accepted (0..4).
REQ-012 SHALL have port last_card, output, 4, value of the most recently accepted card.

Function
REQ-013 SHALL implement FSM states IDLE, DEAL1, HITS, DONE.
REQ-014 SHALL accept only the expected pulse in each state and ignore all other bits:
- IDLE: bit0; next state DEAL1.
- DEAL1: bit1; next state HITS.
- HITS: bit2 while card_cnt=2, bit3 while card_cnt=3.
- DONE: bit0, which clears the hand and accepts a new first card; next state DEAL1.
REQ-015 SHALL, on an accepted pulse in cycle N, update card_cnt, last_card, hard sum and the ace flag at the closing edge of N, so they are visible in N+1.
REQ-016 SHALL take the card value from the source selected by ext_card_en in cycle N; ext_card values 0 or >10 SHALL be clamped to 10.
REQ-017 SHALL map the LFSR to card values as 1..9 unchanged and 10..15 to 10 (face cards).
REQ-018 SHALL implement the LFSR as 4 bits, polynomial x^4+x^3+1, advancing every cycle regardless of state.
REQ-019 SHALL compute hand_sum as hard + 10 when an ace is held and hard <= 11, else hard; hard is 6 bits with a maximum of 40 and no overflow.
REQ-020 SHALL evaluate the result only on acceptance of the second card or later, using the updated effective sum:
- sum = 21: win.
- sum > 21: lose.
- fourth card accepted and sum < 21: lose.
- otherwise: no result.
REQ-021 SHALL register the result at the same edge as the card update, so win_pulse or lose_pulse is high exactly in cycle N+1.
REQ-022 SHALL enter DONE on any result and set the matching latched level (win or lose).
REQ-023 SHALL never assert win_pulse and lose_pulse in the same cycle, and SHALL hold at most one of win and lose.
REQ-024 SHALL, in DONE, keep hand_sum, card_cnt and last_card frozen until the next accepted bit0.
REQ-025 SHALL treat multiple simultaneous card_os bits as follows: only the state-expected bit is considered; all others are ignored.
REQ-026 SHALL clear win and lose at the edge where a new game starts from DONE.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set:
- state to IDLE;
- win, lose, win_pulse, lose_pulse to 0;
- hand_sum, card_cnt, last_card, hard sum and ace flag to 0;
- the LFSR to LFSR_SEED.
REQ-028 SHALL give rst priority over every concurrent card_os pulse; a pulse in a reset cycle is dropped.
REQ-029 SHALL abandon a game interrupted by reset mid-hand without emitting any result pulse.

Structure
REQ-030 SHALL take the state enum, BJ_TARGET=21, ACE_BONUS=10 and FACE_CAP=10 from a shared package blackjack_pkg.
REQ-031 SHALL contain one sub-module, card_lfsr, which provides the LFSR and card mapping (seed parameter, 4-bit value out).

Verification
REQ-032 SHALL cover: ext cards 1 then 10 via bits 0,1 -> hand_sum=21, win_pulse one cycle after bit1 pulse, win=1, state DONE.
REQ-033 SHALL cover: ext cards 10,9,5 via bits 0,1,2 -> hand_sum 19 then 24, lose_pulse after bit2, lose=1.
REQ-034 SHALL cover: ext cards 2,3,4,5 via bits 0..3 -> hand_sum 14 after fourth card, lose_pulse, card_cnt=4.
REQ-035 SHALL cover: out-of-order bit2 pulse in IDLE, then bits 0,1 with cards 1,1 -> bit2 ignored, hand_sum=12, card_cnt=2, no pulse.
REQ-036 SHALL cover: rst asserted in HITS with card_cnt=3 and a coincident bit3 pulse -> all outputs 0, no pulse, state IDLE.
REQ-037 SHALL cover: LFSR source after reset with bit0 pulsed in the first post-reset cycle -> last_card equals the golden-model mapping of the seed sequence.
